// File: rtl/immenc.sv
// immenc: pipelined RV32I immediate encoder, the inverse of immgen.
// Scatters a 32-bit immediate into the format-specific bit positions of a
// base instruction word and flags values the chosen format cannot hold.
// Two register stages: S1 holds the request, S2 holds the packed word.
module immenc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_imm_sel,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    // Format codes shared with immgen; 5..7 are invalid.
    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } imm_fmt_e;

    logic        s1_valid;
    logic [2:0]  s1_sel;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;

    logic        s2_valid;
    logic [31:0] s2_inst;
    logic        s2_err;

    logic        s1_adv;
    logic        s2_adv;
    logic [31:0] pack_inst;
    logic        pack_err;

    // A stage may load whenever it is empty or its contents move on this edge.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = s2_valid;
    assign out_inst  = s2_inst;
    assign out_err   = s2_err;

    // Pack the S1 immediate into the base word and check it fits the format.
    always_comb begin
        pack_inst = s1_base;
        pack_err  = 1'b0;
        case (s1_sel)
            FMT_I: begin
                pack_inst[31:20] = s1_imm[11:0];
                pack_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            FMT_S: begin
                pack_inst[31:25] = s1_imm[11:5];
                pack_inst[11:7]  = s1_imm[4:0];
                pack_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            end
            FMT_B: begin
                pack_inst[31]    = s1_imm[12];
                pack_inst[7]     = s1_imm[11];
                pack_inst[30:25] = s1_imm[10:5];
                pack_inst[11:8]  = s1_imm[4:1];
                pack_err = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
            end
            FMT_U: begin
                pack_inst[31:12] = s1_imm[31:12];
                pack_err = |s1_imm[11:0];
            end
            FMT_J: begin
                pack_inst[31]    = s1_imm[20];
                pack_inst[19:12] = s1_imm[19:12];
                pack_inst[20]    = s1_imm[11];
                pack_inst[30:21] = s1_imm[10:1];
                pack_err = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
            end
            default: begin
                pack_inst = s1_base;
                pack_err  = 1'b1;
            end
        endcase
    end

    // Stage 1: capture the raw request whenever the input handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sel   <= 3'd0;
            s1_imm   <= 32'd0;
            s1_base  <= 32'd0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sel  <= in_imm_sel;
                s1_imm  <= in_imm;
                s1_base <= in_base;
            end
        end
    end

    // Stage 2: hold the packed word until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inst  <= 32'd0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_inst <= pack_inst;
                s2_err  <= pack_err;
            end
        end
    end

    // Count delivered results that carried an error, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (s2_valid && out_ready && s2_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_immenc.sv
// tb_immenc: directed and round-trip checks for the immenc encoder.
module tb_immenc;

    localparam int TB_CNT_W = 3;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_imm_sel;
    logic [31:0]         in_imm;
    logic [31:0]         in_base;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_inst;
    logic                out_err;
    logic [TB_CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    immenc #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm_sel (in_imm_sel),
        .in_imm     (in_imm),
        .in_base    (in_base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference immediate decoder (immgen) used for round-trip checking.
    function automatic logic [31:0] immgen(input logic [2:0] sel, input logic [31:0] i);
        case (sel)
            3'd0:    immgen = {{20{i[31]}}, i[31:20]};
            3'd1:    immgen = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    immgen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    immgen = {i[31:12], 12'd0};
            3'd4:    immgen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: immgen = 32'd0;
        endcase
    endfunction

    // Present one request and hold it until the accepting edge has passed.
    task automatic send_req(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
        int n;
        n = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_imm_sel = sel;
        in_imm     = imm;
        in_base    = base;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for a result, capture it, and let it be consumed.
    task automatic wait_out(output logic [31:0] inst, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_timeout out_valid=%0b want 1", out_valid);
        end
        inst = out_inst;
        err  = out_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_imm_sel = 3'd0;
        in_imm     = 32'd0;
        in_base    = 32'd0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_inst got %h want 00000000", out_inst); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err got %0b want 0", out_err); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got %0d want 0", err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_i_format;
        logic [31:0] inst;
        logic        err;
        out_ready = 1'b1;
        send_req(3'd0, 32'hFFFFF800, 32'h00000013);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL i_latency_early out_valid got %0b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL i_latency out_valid got %0b want 1", out_valid); end
        checks++; if (out_inst !== 32'h80000013) begin errors++; $display("[TB] FAIL i_inst got %h want 80000013", out_inst); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL i_err got %0b want 0", out_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL i_single_out out_valid got %0b want 0", out_valid); end
        send_req(3'd0, 32'h00000800, 32'h00000013);
        wait_out(inst, err);
        checks++; if (inst !== 32'h80000013) begin errors++; $display("[TB] FAIL i_range_inst got %h want 80000013", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL i_range_err got %0b want 1", err); end
        checks++; if (err_cnt !== 3'd1) begin errors++; $display("[TB] FAIL i_range_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_s_format;
        logic [31:0] inst;
        logic        err;
        send_req(3'd1, 32'h000007FF, 32'h00002023);
        wait_out(inst, err);
        checks++; if (inst !== 32'h7E002FA3) begin errors++; $display("[TB] FAIL s_inst got %h want 7E002FA3", inst); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL s_err got %0b want 0", err); end
    endtask

    task automatic test_b_format;
        logic [31:0] inst;
        logic        err;
        send_req(3'd2, 32'hFFFFFFFE, 32'h00000063);
        wait_out(inst, err);
        checks++; if (inst !== 32'hFE000FE3) begin errors++; $display("[TB] FAIL b_inst got %h want FE000FE3", inst); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL b_err got %0b want 0", err); end
        send_req(3'd2, 32'h00000801, 32'h00000063);
        wait_out(inst, err);
        checks++; if (inst !== 32'h000000E3) begin errors++; $display("[TB] FAIL b_odd_inst got %h want 000000E3", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL b_odd_err got %0b want 1", err); end
        checks++; if (err_cnt !== 3'd2) begin errors++; $display("[TB] FAIL b_odd_cnt got %0d want 2", err_cnt); end
    endtask

    task automatic test_ju_format;
        logic [31:0] inst;
        logic        err;
        send_req(3'd4, 32'h000FFFFE, 32'h0000006F);
        wait_out(inst, err);
        checks++; if (inst !== 32'h7FFFF06F) begin errors++; $display("[TB] FAIL j_inst got %h want 7FFFF06F", inst); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL j_err got %0b want 0", err); end
        send_req(3'd3, 32'h12345000, 32'h00000037);
        wait_out(inst, err);
        checks++; if (inst !== 32'h12345037) begin errors++; $display("[TB] FAIL u_inst got %h want 12345037", inst); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL u_err got %0b want 0", err); end
        send_req(3'd3, 32'h12345001, 32'h00000037);
        wait_out(inst, err);
        checks++; if (inst !== 32'h12345037) begin errors++; $display("[TB] FAIL u_low_inst got %h want 12345037", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL u_low_err got %0b want 1", err); end
        checks++; if (err_cnt !== 3'd3) begin errors++; $display("[TB] FAIL u_low_cnt got %0d want 3", err_cnt); end
    endtask

    task automatic test_invalid_sel;
        logic [31:0] inst;
        logic        err;
        send_req(3'd5, 32'h00000004, 32'hA5A5A5A5);
        wait_out(inst, err);
        checks++; if (inst !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL inv_inst got %h want A5A5A5A5", inst); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL inv_err got %0b want 1", err); end
        checks++; if (err_cnt !== 3'd4) begin errors++; $display("[TB] FAIL inv_cnt got %0d want 4", err_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] req_imm [4];
        logic [31:0] exp_inst [4];
        logic [31:0] prev_inst;
        logic        prev_stall;
        logic        saw_block;
        int          idx;
        int          got;
        int          accepts;
        req_imm[0] = 32'h00000001; exp_inst[0] = 32'h00100013;
        req_imm[1] = 32'h00000002; exp_inst[1] = 32'h00200013;
        req_imm[2] = 32'h00000003; exp_inst[2] = 32'h00300013;
        req_imm[3] = 32'h000007FF; exp_inst[3] = 32'h7FF00013;
        idx = 0; got = 0; accepts = 0;
        prev_stall = 1'b0; prev_inst = 32'd0; saw_block = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                in_imm_sel = 3'd0;
                in_imm     = req_imm[idx];
                in_base    = 32'h00000013;
            end
            #1;
            if (!in_ready && !saw_block) begin
                saw_block = 1'b1;
                checks++; if (accepts !== 2) begin errors++; $display("[TB] FAIL bp_block_after accepts got %0d want 2", accepts); end
            end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_inst !== prev_inst) begin errors++; $display("[TB] FAIL bp_stable got %0b/%h want 1/%h", out_valid, out_inst, prev_inst); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_inst !== exp_inst[got]) begin errors++; $display("[TB] FAIL bp_order[%0d] got %h want %h", got, out_inst, exp_inst[got]); end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_inst  = out_inst;
            if (in_valid && in_ready) begin
                accepts++;
                idx++;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("[TB] FAIL bp_count got %0d want 4", got); end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("[TB] FAIL bp_saw_block got %0b want 1", saw_block); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup out_valid got %0b want 0", out_valid); end
        end
    endtask

    task automatic test_round_trip;
        logic [2:0]  q_sel [$];
        logic [31:0] q_imm [$];
        logic [31:0] q_base [$];
        logic [31:0] r;
        logic [31:0] imm;
        logic [31:0] base;
        logic [2:0]  sel;
        logic [31:0] e_imm;
        logic [31:0] e_base;
        logic [2:0]  e_sel;
        int          sent;
        int          got;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000 && !(in_valid && !in_ready)) begin
                r    = $urandom;
                base = $urandom;
                sel  = 3'($urandom_range(0, 4));
                case (sel)
                    3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
                    3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                    3'd3:       imm = {r[31:12], 12'd0};
                    default:    imm = {{11{r[20]}}, r[20:1], 1'b0};
                endcase
                in_valid   = 1'b1;
                in_imm_sel = sel;
                in_imm     = imm;
                in_base    = base;
            end else if (sent >= 1000) begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (q_imm.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL rt_extra got %h want none", out_inst);
                end else begin
                    e_sel  = q_sel.pop_front();
                    e_imm  = q_imm.pop_front();
                    e_base = q_base.pop_front();
                    checks++; if (immgen(e_sel, out_inst) !== e_imm) begin errors++; $display("[TB] FAIL rt_imm[%0d] sel=%0d got %h want %h", got, e_sel, immgen(e_sel, out_inst), e_imm); end
                    checks++; if (out_err !== 1'b0 || out_inst[6:0] !== e_base[6:0]) begin errors++; $display("[TB] FAIL rt_err_op[%0d] got %0b/%h want 0/%h", got, out_err, out_inst[6:0], e_base[6:0]); end
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q_sel.push_back(in_imm_sel);
                q_imm.push_back(in_imm);
                q_base.push_back(in_base);
                sent++;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        checks++; if (got !== 1000) begin errors++; $display("[TB] FAIL rt_count got %0d want 1000", got); end
        checks++; if (err_cnt !== 3'd4) begin errors++; $display("[TB] FAIL rt_cnt got %0d want 4", err_cnt); end
    endtask

    task automatic test_err_saturate;
        logic [31:0] inst;
        logic        err;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_req(3'd7, 32'd0, 32'h00000013);
            wait_out(inst, err);
        end
        checks++; if (err_cnt !== 3'd7) begin errors++; $display("[TB] FAIL sat_reach got %0d want 7", err_cnt); end
        for (int k = 0; k < 3; k++) begin
            send_req(3'd6, 32'd0, 32'h00000013);
            wait_out(inst, err);
        end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL sat_err got %0b want 1", err); end
        checks++; if (err_cnt !== 3'd7) begin errors++; $display("[TB] FAIL sat_hold got %0d want 7", err_cnt); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send_req(3'd0, 32'h00000005, 32'h00000013);
        send_req(3'd0, 32'h00000006, 32'h00000013);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_full got %0b/%0b want 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_out_valid got %0b want 0", out_valid); end
        checks++; if (err_cnt !== 3'd0) begin errors++; $display("[TB] FAIL rm_err_cnt got %0d want 0", err_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_in_ready got %0b want 1", in_ready); end
        checks++; if (out_inst !== 32'd0) begin errors++; $display("[TB] FAIL rm_out_inst got %h want 00000000", out_inst); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_partial out_valid got %0b want 0", out_valid); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset;
        test_i_format;
        test_s_format;
        test_b_format;
        test_ju_format;
        test_invalid_sel;
        test_back_to_back;
        test_round_trip;
        test_err_saturate;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
